// File: rtl/fft_seq_pkg.sv
// Shared types and default constants for the first-stage FFT frame sequencer.
// Contents:
//   seq_state_e             sequencer states (IDLE, RUN, GAP, DRAIN)
//   DEF_BEATS_PER_FRAME     32 beats (16 samples each) per frame
//   DEF_GAP_CYCLES          2 idle cycles between input frames
//   DEF_MAX_INFLIGHT        4 frames started but not yet fully output
//   DEF_FRAME_CNT_W         16-bit frame counters
//   cnt_width()             counter width that never collapses to zero bits
package fft_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_GAP   = 2'd2,
    ST_DRAIN = 2'd3
  } seq_state_e;

  localparam int DEF_BEATS_PER_FRAME = 32;
  localparam int DEF_GAP_CYCLES      = 2;
  localparam int DEF_MAX_INFLIGHT    = 4;
  localparam int DEF_FRAME_CNT_W     = 16;

  // Width for a counter spanning 0..n-1; at least one bit so degenerate
  // parameter choices still elaborate.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fft_seq_out_tracker.sv
// Output-side frame tracker for module1.
// Counts module1 output beats and flags the first and last beat of each frame.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   valid     module1 valid_out
//   sof       first output beat of a frame (combinational, qualified by valid)
//   eof       last output beat of a frame (combinational, qualified by valid)
module fft_seq_out_tracker
  import fft_seq_pkg::*;
#(
  parameter int BEATS_PER_FRAME = DEF_BEATS_PER_FRAME
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  output logic sof,
  output logic eof
);

  localparam int BEAT_W = cnt_width(BEATS_PER_FRAME);
  localparam logic [BEAT_W-1:0] BEAT_ZERO = {BEAT_W{1'b0}};
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_FRAME - 1);

  logic [BEAT_W-1:0] out_beat_r;

  assign sof = valid & (out_beat_r == BEAT_ZERO);
  assign eof = valid & (out_beat_r == LAST_BEAT);

  // Output beat counter; returns to zero on the last beat of every frame
  always_ff @(posedge clk) begin
    if (rst) begin
      out_beat_r <= BEAT_ZERO;
    end else if (eof) begin
      out_beat_r <= BEAT_ZERO;
    end else if (valid) begin
      out_beat_r <= out_beat_r + 1'b1;
    end else begin
      out_beat_r <= out_beat_r;
    end
  end

endmodule

// File: rtl/fft_stage1_seq.sv
// Frame sequencer for FFT stage 1 (butterfly10/11/12 + CBFP1).
// Gates the 16-lane source stream into module1 as fixed-length frames,
// inserts inter-frame gaps, bounds frames in flight and tracks module1
// output beats for frame start/end markers. Data buses bypass this block.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, stop               arm pulse / finish-frame-then-drain pulse
//   src_valid, src_ready      source handshake (src_ready combinational)
//   m1_din_valid              module1 din_valid = src_valid & src_ready
//   m1_valid_out              module1 valid_out
//   out_sof, out_eof          output frame markers (combinational)
//   busy, inflight            activity and frames-in-flight status
//   frames_in, frames_out     wrapping completed-frame counters
//   err_bubble, err_spurious  sticky protocol errors
// Optional feature macro: FFT_SEQ_ERRCHK_EN enables the error checks; when
// undefined both error flags are tied low.
module fft_stage1_seq
  import fft_seq_pkg::*;
#(
  parameter int BEATS_PER_FRAME = DEF_BEATS_PER_FRAME,
  parameter int GAP_CYCLES      = DEF_GAP_CYCLES,
  parameter int MAX_INFLIGHT    = DEF_MAX_INFLIGHT,
  parameter int FRAME_CNT_W     = DEF_FRAME_CNT_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              stop,
  input  logic                              src_valid,
  output logic                              src_ready,
  output logic                              m1_din_valid,
  input  logic                              m1_valid_out,
  output logic                              out_sof,
  output logic                              out_eof,
  output logic                              busy,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic [FRAME_CNT_W-1:0]            frames_in,
  output logic [FRAME_CNT_W-1:0]            frames_out,
  output logic                              err_bubble,
  output logic                              err_spurious
);

  localparam int IF_W   = $clog2(MAX_INFLIGHT + 1);
  localparam int BEAT_W = cnt_width(BEATS_PER_FRAME);
  localparam int GAP_W  = cnt_width(GAP_CYCLES);

  localparam logic [BEAT_W-1:0] BEAT_ZERO = {BEAT_W{1'b0}};
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_FRAME - 1);
  localparam logic [GAP_W-1:0]  GAP_ZERO  = {GAP_W{1'b0}};
  localparam logic [GAP_W-1:0]  LAST_GAP  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IF_W-1:0]   IF_ZERO   = {IF_W{1'b0}};
  localparam logic [IF_W-1:0]   MAX_IF    = IF_W'(MAX_INFLIGHT);

  seq_state_e             state_r;
  logic [BEAT_W-1:0]      in_beat_r;
  logic [GAP_W-1:0]       gap_cnt_r;
  logic                   stop_pend_r;
  logic [IF_W-1:0]        inflight_r;
  logic [FRAME_CNT_W-1:0] frames_in_r;
  logic [FRAME_CNT_W-1:0] frames_out_r;

  logic            ready_s;
  logic            stop_any_s;
  logic            accept_s;
  logic            first_beat_s;
  logic            last_beat_s;
  logic            dec_s;
  logic            out_sof_s;
  logic            out_eof_s;
  logic [IF_W-1:0] inflight_nxt_s;

  // A stop arriving this cycle counts as pending immediately so a new frame
  // is never opened in the same cycle the stop is seen.
  assign stop_any_s = stop | stop_pend_r;

  // Source handshake: a new frame may only open while the in-flight budget
  // has room; once a frame has begun its remaining beats are always taken.
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (in_beat_r == BEAT_ZERO) begin
          ready_s = (inflight_r < MAX_IF) & ~stop_any_s;
        end else begin
          ready_s = 1'b1;
        end
      end
      default: ready_s = 1'b0;
    endcase
  end

  assign accept_s     = src_valid & ready_s;
  assign first_beat_s = accept_s & (in_beat_r == BEAT_ZERO);
  assign last_beat_s  = accept_s & (in_beat_r == LAST_BEAT);
  // An end-of-frame with nothing in flight is spurious; never underflow.
  assign dec_s        = out_eof_s & (inflight_r != IF_ZERO);

  // In-flight frame count for the next cycle; start and finish together cancel
  always_comb begin
    inflight_nxt_s = inflight_r;
    if (first_beat_s && !dec_s) begin
      inflight_nxt_s = inflight_r + 1'b1;
    end else if (dec_s && !first_beat_s) begin
      inflight_nxt_s = inflight_r - 1'b1;
    end else begin
      inflight_nxt_s = inflight_r;
    end
  end

  fft_seq_out_tracker #(
    .BEATS_PER_FRAME(BEATS_PER_FRAME)
  ) u_out_tracker (
    .clk  (clk),
    .rst  (rst),
    .valid(m1_valid_out),
    .sof  (out_sof_s),
    .eof  (out_eof_s)
  );

  // Sequencer FSM together with beat, gap, in-flight and frame accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      in_beat_r    <= BEAT_ZERO;
      gap_cnt_r    <= GAP_ZERO;
      stop_pend_r  <= 1'b0;
      inflight_r   <= IF_ZERO;
      frames_in_r  <= {FRAME_CNT_W{1'b0}};
      frames_out_r <= {FRAME_CNT_W{1'b0}};
    end else begin
      inflight_r <= inflight_nxt_s;
      if (last_beat_s) begin
        frames_in_r <= frames_in_r + 1'b1;
      end
      if (out_eof_s) begin
        frames_out_r <= frames_out_r + 1'b1;
      end

      case (state_r)
        ST_IDLE: begin
          in_beat_r <= BEAT_ZERO;
          gap_cnt_r <= GAP_ZERO;
          // stop is ignored here and also overrides a simultaneous start
          if (start && !stop) begin
            state_r <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (stop) begin
            stop_pend_r <= 1'b1;
          end
          if (last_beat_s) begin
            in_beat_r <= BEAT_ZERO;
            gap_cnt_r <= GAP_ZERO;
            if (stop_any_s) begin
              state_r <= ST_DRAIN;
            end else if (GAP_CYCLES > 0) begin
              state_r <= ST_GAP;
            end else begin
              state_r <= ST_RUN;
            end
          end else if (accept_s) begin
            in_beat_r <= in_beat_r + 1'b1;
          end else if ((in_beat_r == BEAT_ZERO) && stop_any_s) begin
            // frame boundary: nothing open, so drain straight away
            state_r <= ST_DRAIN;
          end
        end

        ST_GAP: begin
          if (stop) begin
            stop_pend_r <= 1'b1;
          end
          if (gap_cnt_r == LAST_GAP) begin
            gap_cnt_r <= GAP_ZERO;
            state_r   <= stop_any_s ? ST_DRAIN : ST_RUN;
          end else begin
            gap_cnt_r <= gap_cnt_r + 1'b1;
          end
        end

        ST_DRAIN: begin
          // Leave on the edge that retires the final frame so busy drops
          // in the cycle right after the last end-of-frame beat.
          if (inflight_nxt_s == IF_ZERO) begin
            state_r     <= ST_IDLE;
            stop_pend_r <= 1'b0;
          end
        end

        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FFT_SEQ_ERRCHK_EN
  logic err_bubble_r;
  logic err_spurious_r;

  // Sticky capture of mid-frame source gaps and unexpected module1 output
  always_ff @(posedge clk) begin
    if (rst) begin
      err_bubble_r   <= 1'b0;
      err_spurious_r <= 1'b0;
    end else begin
      // CBFP1 needs contiguous beats within a frame
      if ((state_r == ST_RUN) && (in_beat_r != BEAT_ZERO) && !src_valid) begin
        err_bubble_r <= 1'b1;
      end
      if (m1_valid_out && (inflight_r == IF_ZERO)) begin
        err_spurious_r <= 1'b1;
      end
    end
  end

  assign err_bubble   = err_bubble_r;
  assign err_spurious = err_spurious_r;
`else
  assign err_bubble   = 1'b0;
  assign err_spurious = 1'b0;
`endif

  assign src_ready    = ready_s;
  assign m1_din_valid = accept_s;
  assign out_sof      = out_sof_s;
  assign out_eof      = out_eof_s;
  assign busy         = (state_r != ST_IDLE);
  assign inflight     = inflight_r;
  assign frames_in    = frames_in_r;
  assign frames_out   = frames_out_r;

endmodule

// File: tb/tb_fft_stage1_seq.sv
// Self-checking bench for fft_stage1_seq: a table of single-cycle control
// vectors plus hand-written multi-cycle sequences. module1 is modelled either
// as a 40-cycle delay of m1_din_valid or as a manually driven valid_out.
`timescale 1ns/1ps
module tb_fft_stage1_seq;

  localparam int BPF  = 32;
  localparam int GAP  = 2;
  localparam int MAXF = 4;
  localparam int FW   = 16;
  localparam int IFW  = $clog2(MAXF + 1);
  localparam int LAT  = 40;
`ifdef FFT_SEQ_ERRCHK_EN
  localparam logic ERRCHK = 1'b1;
`else
  localparam logic ERRCHK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst, start, stop, src_valid;
  logic           src_ready, m1_din_valid, m1_valid_out;
  logic           out_sof, out_eof, busy, err_bubble, err_spurious;
  logic [IFW-1:0] inflight;
  logic [FW-1:0]  frames_in, frames_out;

  logic           loop_en, m1_man;
  logic [LAT-1:0] dly;

  always #5 clk = ~clk;

  // module1 latency model
  always @(posedge clk) begin
    if (rst) dly <= '0;
    else     dly <= {dly[LAT-2:0], m1_din_valid};
  end
  assign m1_valid_out = loop_en ? dly[LAT-1] : m1_man;

  fft_stage1_seq #(
    .BEATS_PER_FRAME(BPF), .GAP_CYCLES(GAP), .MAX_INFLIGHT(MAXF), .FRAME_CNT_W(FW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .src_valid(src_valid), .src_ready(src_ready), .m1_din_valid(m1_din_valid),
    .m1_valid_out(m1_valid_out), .out_sof(out_sof), .out_eof(out_eof),
    .busy(busy), .inflight(inflight), .frames_in(frames_in), .frames_out(frames_out),
    .err_bubble(err_bubble), .err_spurious(err_spurious)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; src_valid = 1'b1;
    loop_en = 1'b0; m1_man = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  typedef struct {
    logic start, stop, sv, mv;
    logic e_ready, e_dv, e_busy, e_sof, e_eof;
  } vec_t;
  vec_t tbl[8];

  int acc, outk, t, first_out, e_t, a_t, rdy_after, gap_low, n;
  int acc_t[64];
  logic busy_at[160];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //              start stop  sv    mv    ready dv    busy  sof   eof
    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // idle holds off
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // stop in idle ignored
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // start+stop: stop wins
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // still idle
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // start edge
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // first beat taken
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}; // first output beat
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // bubble mid-frame

    // ---- reset state ----
    do_reset();
    @(negedge clk);
    chk("rst_ready", src_ready, 0);
    chk("rst_dv", m1_din_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_frames_in", frames_in, 0);
    chk("rst_frames_out", frames_out, 0);
    chk("rst_err_b", err_bubble, 0);
    chk("rst_err_s", err_spurious, 0);
    cyc();

    // ---- table-driven control vectors ----
    for (int i = 0; i < 8; i++) begin
      start = tbl[i].start; stop = tbl[i].stop;
      src_valid = tbl[i].sv; m1_man = tbl[i].mv;
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), src_ready, tbl[i].e_ready);
      chk($sformatf("v%0d_dv", i), m1_din_valid, tbl[i].e_dv);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("v%0d_sof", i), out_sof, tbl[i].e_sof);
      chk($sformatf("v%0d_eof", i), out_eof, tbl[i].e_eof);
      cyc();
    end
    start = 1'b0; stop = 1'b0; m1_man = 1'b0; src_valid = 1'b1;
    @(negedge clk);
    chk("err_bubble_set", err_bubble, ERRCHK);
    cyc(); cyc(); cyc();
    @(negedge clk);
    chk("err_bubble_sticky", err_bubble, ERRCHK);
    chk("err_spur_clear", err_spurious, 0);
    cyc();

    // ---- spurious output while idle ----
    do_reset();
    src_valid = 1'b0; m1_man = 1'b1;
    @(negedge clk);
    chk("spur_before", err_spurious, 0);
    cyc();
    m1_man = 1'b0;
    @(negedge clk);
    chk("spur_set", err_spurious, ERRCHK);
    cyc(); cyc(); cyc();
    @(negedge clk);
    chk("spur_sticky", err_spurious, ERRCHK);
    chk("spur_no_bubble", err_bubble, 0);
    cyc();

    // ---- two frames with gap and 40-cycle loopback ----
    do_reset();
    loop_en = 1'b1; start = 1'b1; cyc(); start = 1'b0; src_valid = 1'b1;
    acc = 0; outk = 0; t = 0; first_out = -1;
    while ((acc < 64 || outk < 64) && t < 300) begin
      @(negedge clk);
      if (src_ready && src_valid) begin
        if (acc < 64) acc_t[acc] = t;
        acc++;
      end
      if (m1_valid_out) begin
        chk($sformatf("a_sof%0d", outk), out_sof, (outk % BPF) == 0);
        chk($sformatf("a_eof%0d", outk), out_eof, (outk % BPF) == BPF - 1);
        if (outk == 0) first_out = t;
        outk++;
      end
      cyc(); t++;
      if (acc >= 64) src_valid = 1'b0;
    end
    @(negedge clk);
    chk("a_beats", acc, 64);
    chk("a_outs", outk, 64);
    chk("a_first_beat_t", acc_t[0], 0);
    chk("a_last_beat_f0_t", acc_t[31], 31);
    chk("a_first_beat_f1_t", acc_t[32], 31 + GAP + 1);
    chk("a_last_beat_f1_t", acc_t[63], 31 + GAP + 1 + 31);
    chk("a_latency", first_out, LAT);
    chk("a_frames_in", frames_in, 2);
    chk("a_frames_out", frames_out, 2);
    chk("a_inflight", inflight, 0);
    chk("a_busy_run", busy, 1);
    cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    n = 0;
    @(negedge clk);
    while (busy && n < 10) begin
      cyc(); @(negedge clk); n++;
    end
    chk("a_idle_after_stop", busy, 0);
    cyc();

    // ---- in-flight limit ----
    do_reset();
    loop_en = 1'b0; m1_man = 1'b0;
    start = 1'b1; cyc(); start = 1'b0; src_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 170; i++) begin
      @(negedge clk);
      if (src_ready && src_valid) acc++;
      cyc();
    end
    @(negedge clk);
    chk("b_beats", acc, 4 * BPF);
    chk("b_ready_blocked", src_ready, 0);
    chk("b_inflight", inflight, MAXF);
    chk("b_frames_in", frames_in, 4);
    cyc();
    outk = 0; e_t = -1; a_t = -1; t = 0;
    while (a_t < 0 && t < 80) begin
      m1_man = (outk < BPF);
      @(negedge clk);
      if (m1_valid_out) begin
        if (out_eof) e_t = t;
        outk++;
      end
      if (src_ready && src_valid && a_t < 0) a_t = t;
      cyc(); t++;
    end
    m1_man = 1'b0;
    chk("b_eof_t", e_t, BPF - 1);
    chk("b_resume_t", a_t, BPF);
    @(negedge clk);
    chk("b_inflight_after", inflight, MAXF);
    cyc();

    // ---- stop mid-frame, drain to idle ----
    do_reset();
    loop_en = 1'b1; start = 1'b1; cyc(); start = 1'b0; src_valid = 1'b1;
    acc = 0; outk = 0; t = 0; e_t = -1; rdy_after = 0;
    while (t < 150) begin
      stop = (acc == 10);
      @(negedge clk);
      busy_at[t] = busy;
      if (acc >= BPF && src_ready) rdy_after++;
      if (src_ready && src_valid) acc++;
      if (m1_valid_out) begin
        if (out_eof) e_t = t;
        outk++;
      end
      cyc(); t++;
    end
    stop = 1'b0;
    chk("c_beats", acc, BPF);
    chk("c_outs", outk, BPF);
    chk("c_ready_after_stop", rdy_after, 0);
    chk("c_eof_t", e_t, BPF - 1 + LAT);
    chk("c_busy_draining", busy_at[BPF + 5], 1);
    chk("c_busy_at_eof", busy_at[BPF - 1 + LAT], 1);
    chk("c_idle_after_eof", busy_at[BPF + LAT], 0);
    chk("c_frames_out", frames_out, 1);

    // ---- reset mid-frame, then a fresh frame ----
    do_reset();
    loop_en = 1'b0; start = 1'b1; cyc(); start = 1'b0; src_valid = 1'b1;
    acc = 0; t = 0;
    while (acc < 12 && t < 40) begin
      m1_man = (acc >= 2 && acc < 8);
      @(negedge clk);
      if (src_ready && src_valid) acc++;
      cyc(); t++;
    end
    m1_man = 1'b0;
    rst = 1'b1; cyc(); rst = 1'b0;
    @(negedge clk);
    chk("e_ready", src_ready, 0);
    chk("e_dv", m1_din_valid, 0);
    chk("e_busy", busy, 0);
    chk("e_inflight", inflight, 0);
    chk("e_frames_in", frames_in, 0);
    chk("e_frames_out", frames_out, 0);
    cyc();
    start = 1'b1; cyc(); start = 1'b0;
    acc = 0; gap_low = 0;
    for (int i = 0; i < BPF + GAP; i++) begin
      m1_man = (i == 3);
      @(negedge clk);
      if (i == 3) chk("e_sof_restart", out_sof, 1);
      if (src_ready && src_valid) acc++;
      if (i >= BPF && !src_ready) gap_low++;
      cyc();
    end
    m1_man = 1'b0;
    @(negedge clk);
    chk("e_beats", acc, BPF);
    chk("e_gap_low", gap_low, GAP);
    chk("e_frames_in", frames_in, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_stage1_seq.md
# fft_stage1_seq

Frame sequencer for the first FFT stage (module1: butterfly10/11/12 + CBFP1). It gates the 16-lane source stream into module1 as 32-beat frames (512 points). It inserts configurable inter-frame gaps for CBFP block alignment and bounds the number of frames in flight. It also tracks module1 output beats to produce frame start/end markers. The block sits between the sample source and module1; data buses bypass it, and only the control signals pass through it.

## Interface
- BEATS_PER_FRAME, 32: input/output beats per frame (16 samples per beat).
- GAP_CYCLES, 2: idle cycles forced between input frames; 0 means back-to-back.
- MAX_INFLIGHT, 4: maximum frames started but not yet fully output.
- FRAME_CNT_W, 16: width of the frame counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; arms the sequencer.
- stop  in  1  pulse; finish the current frame, drain, then go idle.
- src_valid  in  1  source beat available.
- src_ready  out  1  sequencer accepts a beat this cycle.
- m1_din_valid  out  1  drives module1 din_valid; equals src_valid & src_ready (combinational).
- m1_valid_out  in  1  module1 valid_out.
- out_sof  out  1  first output beat of a frame (combinational, qualified by m1_valid_out).
- out_eof  out  1  last output beat of a frame.
- busy  out  1  state != IDLE.
- inflight  out  $clog2(MAX_INFLIGHT+1)  frames in flight.
- frames_in  out  FRAME_CNT_W  completed input frames, wraps.
- frames_out  out  FRAME_CNT_W  completed output frames, wraps.
- err_bubble, err_spurious  out  1 each  sticky error flags (see Configuration).

## Operation
- States: IDLE, RUN, GAP, DRAIN.
- IDLE: src_ready=0. start → RUN. A start while not IDLE is ignored.
- RUN: in_beat counts accepted beats, 0..BEATS_PER_FRAME-1.
  - When in_beat==0, src_ready = (inflight < MAX_INFLIGHT). When in_beat>0, src_ready=1.
  - Accepting a beat with in_beat==0 increments inflight.
  - Accepting the last beat increments frames_in and resets in_beat to 0.
  - After the last beat, next state is: DRAIN if a stop is pending; else GAP if GAP_CYCLES>0; else RUN.
- GAP: src_ready=0. Counts GAP_CYCLES cycles, then goes to RUN, or to DRAIN if a stop is pending.
- stop: sets stop_pend.
  - In RUN with in_beat==0, go to DRAIN the next cycle.
  - In RUN mid-frame, the frame completes first.
  - In IDLE, stop is ignored.
- DRAIN: src_ready=0. When inflight==0, go to IDLE and clear stop_pend.
- start and stop in the same cycle: stop wins.
- Output side: out_beat counts m1_valid_out beats.
  - out_sof = m1_valid_out & out_beat==0.
  - out_eof = m1_valid_out & out_beat==BEATS_PER_FRAME-1.
  - On out_eof: decrement inflight, increment frames_out, reset out_beat to 0.
- Simultaneous inflight increment and decrement leaves inflight unchanged.
- Counters frames_in and frames_out wrap modulo 2^FRAME_CNT_W.

## Timing
- Reset (rst sampled high at a clk edge) clears:
  - state=IDLE, src_ready=0, m1_din_valid=0, busy=0;
  - inflight=0, frames_in=0, frames_out=0, in_beat=0, out_beat=0, stop_pend=0;
  - err_bubble=0, err_spurious=0.
- Reset mid-frame abandons the frame with no flush; the output-side count restarts at 0.
- start at edge N → RUN and src_ready=1 from cycle N+1 (when inflight < MAX).
- Frame timing with continuous src_valid:
  - last beat accepted at cycle T;
  - src_ready=0 for cycles T+1..T+GAP_CYCLES;
  - next frame's first beat is accepted at T+GAP_CYCLES+1.
- State, counters and inflight update one cycle after the qualifying event.
- src_ready, m1_din_valid, out_sof and out_eof are combinational from registered state and inputs.

## Configuration
- FFT_SEQ_ERRCHK_EN defined:
  - err_bubble is set when src_valid=0 in RUN with in_beat>0, because CBFP1 requires contiguous beats. The beat still waits.
  - err_spurious is set when m1_valid_out=1 while inflight==0.
  - Both flags are sticky until rst.
- Not defined: both flags are tied to 0 and the check logic is absent.

## Structure
- Package fft_seq_pkg holds:
  - the state enum typedef (IDLE/RUN/GAP/DRAIN);
  - the default constants BEATS_PER_FRAME=32, GAP_CYCLES=2, MAX_INFLIGHT=4.
- Sub-module fft_seq_out_tracker holds the out_beat counter and the out_sof/out_eof generation. The sequencer FSM and inflight accounting stay in the top.

## Test plan
- Reset, then start with continuous src_valid for 2 frames → 32 accepted beats, 2 ready-low gap cycles, 32 beats; frames_in=2.
- Loop m1_valid_out back from m1_din_valid delayed 40 cycles → out_sof at output beats 0 and 32, out_eof at 31 and 63; inflight returns to 0; frames_out=2.
- MAX_INFLIGHT=4, m1_valid_out held low → exactly 4 frames (128 beats) accepted, then src_ready stays 0 at the frame boundary. Release outputs → the 5th frame starts after the first out_eof.
- stop at input beat 10 → frame completes to beat 31, state goes to DRAIN; IDLE and busy=0 one cycle after the last out_eof.
- With FFT_SEQ_ERRCHK_EN: drop src_valid at beat 5 → err_bubble=1 and stays set. Pulse m1_valid_out at idle → err_spurious=1. Without the macro both flags stay 0.
- rst mid-frame at beat 12 → all outputs return to reset values next cycle. A fresh start sends a full 32-beat frame with in_beat counting from 0.
